// File: rtl/cache_line_sequencer.sv
// Sequences one cache-line refill, writeback-then-refill or flush between the data array and memory.
// A clean refill with zero-wait memory completes 5 cycles after accept. It waits on mem ready and on the fill response, and accepts a request only in IDLE.
module cache_line_sequencer #(
  parameter int ADDR_W = 26
) (
  input  logic              main_clk,
  input  logic              main_rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_op,
  input  logic [10:0]       req_segment,
  input  logic [1:0]        req_way,
  input  logic [ADDR_W-1:0] req_wb_addr,
  input  logic [ADDR_W-1:0] req_fill_addr,
  output logic              done,
  output logic              done_wrote_back,
  output logic              busy,
  output logic [10:0]       cd_target_segment,
  output logic [1:0]        cd_target_way,
  output logic              cd_do_full_write,
  output logic [127:0]      cd_raw_in,
  input  logic [127:0]      cd_raw_out,
  input  logic              cd_dirty,
  output logic              mem_wr_valid,
  input  logic              mem_wr_ready,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [127:0]      mem_wr_data,
  output logic              mem_rd_valid,
  input  logic              mem_rd_ready,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic              mem_rd_resp_valid,
  input  logic [127:0]      mem_rd_resp_data
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RD    = 3'd1;
  localparam logic [2:0] S_CAP   = 3'd2;
  localparam logic [2:0] S_WB    = 3'd3;
  localparam logic [2:0] S_FREQ  = 3'd4;
  localparam logic [2:0] S_FWAIT = 3'd5;
  localparam logic [2:0] S_WR    = 3'd6;

  typedef struct packed {
    logic              op;
    logic [10:0]       segment;
    logic [1:0]        way;
    logic [ADDR_W-1:0] wb_addr;
    logic [ADDR_W-1:0] fill_addr;
  } req_t;

  logic [2:0]   state;
  logic [2:0]   state_nxt;
  req_t         req_q;
  logic [127:0] wb_buf;
  logic [127:0] fill_buf;
  logic         dirty_q;
  logic         accept;

  assign accept = (state == S_IDLE) && req_valid;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (req_valid) state_nxt = S_RD;
      S_RD:    state_nxt = S_CAP;
      // cd_dirty arrives one cycle after the RD address, i.e. during CAP
      S_CAP: begin
        if (cd_dirty)      state_nxt = S_WB;
        else if (req_q.op) state_nxt = S_IDLE;
        else               state_nxt = S_FREQ;
      end
      S_WB:    if (mem_wr_ready) state_nxt = req_q.op ? S_IDLE : S_FREQ;
      S_FREQ:  if (mem_rd_ready) state_nxt = S_FWAIT;
      S_FWAIT: if (mem_rd_resp_valid) state_nxt = S_WR;
      S_WR:    state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge main_clk or posedge main_rst) begin
    if (main_rst) begin
      state    <= S_IDLE;
      req_q    <= '0;
      wb_buf   <= '0;
      fill_buf <= '0;
      dirty_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        req_q.op        <= req_op;
        req_q.segment   <= req_segment;
        req_q.way       <= req_way;
        req_q.wb_addr   <= req_wb_addr;
        req_q.fill_addr <= req_fill_addr;
      end
      if (state == S_CAP) begin
        wb_buf  <= cd_raw_out;
        dirty_q <= cd_dirty;
      end
      if (state == S_FWAIT && mem_rd_resp_valid) begin
        fill_buf <= mem_rd_resp_data;
      end
    end
  end

  assign req_ready = (state == S_IDLE) && !main_rst;
  assign busy      = (state != S_IDLE);

  assign cd_target_segment = req_q.segment;
  assign cd_target_way     = req_q.way;
  assign cd_do_full_write  = (state == S_WR);
  assign cd_raw_in         = fill_buf;

  assign mem_wr_valid = (state == S_WB);
  assign mem_wr_addr  = req_q.wb_addr;
  assign mem_wr_data  = wb_buf;
  assign mem_rd_valid = (state == S_FREQ);
  assign mem_rd_addr  = req_q.fill_addr;

  // Three completion points: clean flush in CAP, dirty flush on WB accept, any refill in WR
  assign done = ((state == S_CAP) && !cd_dirty && req_q.op)
             || ((state == S_WB) && mem_wr_ready && req_q.op)
             || (state == S_WR);
  assign done_wrote_back = done && ((state == S_WB) || ((state == S_WR) && dirty_q));

endmodule

// File: tb/tb_cache_line_sequencer.sv
// Bench for cache_line_sequencer: table of directed transactions, hand-written reset and back-to-back
// sequences, and randomized transactions checked against an array/latency model.
module tb_cache_line_sequencer;
  localparam int ADDR_W = 26;

  logic              main_clk = 1'b0;
  logic              main_rst;
  logic              req_valid;
  logic              req_ready;
  logic              req_op;
  logic [10:0]       req_segment;
  logic [1:0]        req_way;
  logic [ADDR_W-1:0] req_wb_addr;
  logic [ADDR_W-1:0] req_fill_addr;
  logic              done;
  logic              done_wrote_back;
  logic              busy;
  logic [10:0]       cd_target_segment;
  logic [1:0]        cd_target_way;
  logic              cd_do_full_write;
  logic [127:0]      cd_raw_in;
  logic [127:0]      cd_raw_out;
  logic              cd_dirty;
  logic              mem_wr_valid;
  logic              mem_wr_ready;
  logic [ADDR_W-1:0] mem_wr_addr;
  logic [127:0]      mem_wr_data;
  logic              mem_rd_valid;
  logic              mem_rd_ready;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic              mem_rd_resp_valid;
  logic [127:0]      mem_rd_resp_data;

  always #5 main_clk = ~main_clk;

  cache_line_sequencer #(.ADDR_W(ADDR_W)) dut (
    .main_clk(main_clk), .main_rst(main_rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_segment(req_segment), .req_way(req_way),
    .req_wb_addr(req_wb_addr), .req_fill_addr(req_fill_addr),
    .done(done), .done_wrote_back(done_wrote_back), .busy(busy),
    .cd_target_segment(cd_target_segment), .cd_target_way(cd_target_way),
    .cd_do_full_write(cd_do_full_write), .cd_raw_in(cd_raw_in),
    .cd_raw_out(cd_raw_out), .cd_dirty(cd_dirty),
    .mem_wr_valid(mem_wr_valid), .mem_wr_ready(mem_wr_ready),
    .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .mem_rd_valid(mem_rd_valid), .mem_rd_ready(mem_rd_ready), .mem_rd_addr(mem_rd_addr),
    .mem_rd_resp_valid(mem_rd_resp_valid), .mem_rd_resp_data(mem_rd_resp_data)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Array contents as seen by the bench, keyed by {segment, way}
  logic [127:0] m_data [int];
  bit           m_dirty [int];
  int           prev_idx = 0;

  typedef struct {
    logic         op;
    logic [10:0]  seg;
    logic [1:0]   way;
    bit           dirty;
    logic [127:0] victim;
    logic [127:0] fdata;
    int           wr_stall;
    int           rd_stall;
    int           resp_delay;
    bit           stray;
    int           exp_done;
    bit           exp_wb;
  } vec_t;

  typedef struct {
    int           done_c;
    bit           wb;
    int           wr_hs;
    int           rd_hs;
    int           arr_wr;
    int           wr_cycles;
    int           proto_err;
    int           busy_viol;
    int           wait_c;
    logic [127:0] wr_data;
  } obs_t;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] m_get(input int idx);
    return m_data.exists(idx) ? m_data[idx] : 128'h0;
  endfunction

  function automatic bit m_get_dirty(input int idx);
    return m_dirty.exists(idx) ? m_dirty[idx] : 1'b0;
  endfunction

  // Latency from the spec's rules: RD=1, CAP=2, WB lasts stall+1, FREQ stall+1, FWAIT delay+1, then WR
  function automatic int exp_done_cycle(input bit op, input bit dirty, input int ws, input int rs, input int rd);
    int t;
    t = 2;
    if (dirty) t = t + 1 + ws;
    if (op) return t;
    return t + (1 + rs) + (1 + rd) + 1;
  endfunction

  // Registered array read: data presented this cycle belongs to last cycle's address
  task automatic drive_array();
    int idx_now;
    idx_now    = int'({cd_target_segment, cd_target_way});
    cd_raw_out = m_get(prev_idx);
    cd_dirty   = m_get_dirty(prev_idx);
    prev_idx   = idx_now;
  endtask

  task automatic run_txn(input vec_t v, input logic [ADDR_W-1:0] wba, input logic [ADDR_W-1:0] fa,
                         input bit keep_valid, input int rst_at, output obs_t o);
    int idx, wb_k, rd_k, fw_k;
    bit in_fw, dirty;
    logic [127:0] victim;
    idx = int'({v.seg, v.way});
    victim = m_get(idx);
    dirty = m_get_dirty(idx);
    o = '{default: 0};
    o.done_c = -1;
    wb_k = 0; rd_k = 0; fw_k = 0; in_fw = 0;

    @(negedge main_clk);
    drive_array();
    mem_wr_ready = 1'b0; mem_rd_ready = 1'b0; mem_rd_resp_valid = 1'b0;
    req_valid = 1'b1; req_op = v.op; req_segment = v.seg; req_way = v.way;
    req_wb_addr = wba; req_fill_addr = fa;
    #1;
    while (!req_ready && o.wait_c < 20) begin
      @(negedge main_clk);
      drive_array();
      o.wait_c++;
      #1;
    end
    if (!req_ready) begin
      chk("accept_timeout", 128'(req_ready), 128'(1));
      return;
    end
    if (busy || done) o.busy_viol++;

    for (int c = 1; c <= 300; c++) begin
      @(negedge main_clk);
      if (!keep_valid) req_valid = 1'b0;
      drive_array();
      if (c == rst_at) begin
        main_rst = 1'b1;
        req_valid = 1'b0;
        #1;
        chk("rst_ctrl_zero", 128'({busy, req_ready, done, done_wrote_back, cd_do_full_write,
                                   mem_wr_valid, mem_rd_valid}), 128'(0));
        chk("rst_regs_zero", 128'({cd_target_segment, cd_target_way, mem_wr_addr, mem_rd_addr}), 128'(0));
        chk("rst_data_zero", mem_wr_data | cd_raw_in, 128'(0));
        @(negedge main_clk);
        main_rst = 1'b0;
        // Late memory activity after reset must not revive the aborted transaction
        for (int k = 0; k < 6; k++) begin
          @(negedge main_clk);
          drive_array();
          mem_rd_resp_valid = 1'b1; mem_rd_resp_data = v.fdata;
          mem_wr_ready = 1'b1; mem_rd_ready = 1'b1;
          #1;
          if (done || cd_do_full_write || busy) o.busy_viol++;
        end
        mem_rd_resp_valid = 1'b0;
        return;
      end

      if (mem_wr_valid) begin
        mem_wr_ready = (wb_k >= v.wr_stall);
        wb_k++;
      end else mem_wr_ready = 1'($urandom_range(0, 1));
      if (mem_rd_valid) begin
        mem_rd_ready = (rd_k >= v.rd_stall);
        rd_k++;
      end else mem_rd_ready = 1'($urandom_range(0, 1));
      if (in_fw) begin
        mem_rd_resp_valid = (fw_k == v.resp_delay);
        mem_rd_resp_data  = mem_rd_resp_valid ? v.fdata : ~v.fdata;
        if (mem_rd_resp_valid) in_fw = 0;
        fw_k++;
      end else begin
        mem_rd_resp_valid = v.stray && (mem_wr_valid || $urandom_range(0, 3) == 0);
        mem_rd_resp_data  = ~v.fdata;
      end
      if (mem_rd_valid && mem_rd_ready) begin
        in_fw = 1;
        fw_k = 0;
      end

      #1;
      if (!busy || req_ready) o.busy_viol++;
      if ({cd_target_segment, cd_target_way} !== {v.seg, v.way}) o.proto_err++;
      if (!done && done_wrote_back) o.proto_err++;
      if (mem_wr_valid) begin
        if (mem_wr_addr !== wba || mem_wr_data !== victim) o.proto_err++;
        if (mem_wr_ready) o.wr_hs++;
        o.wr_cycles++;
      end
      if (mem_rd_valid) begin
        if (mem_rd_addr !== fa) o.proto_err++;
        if (mem_rd_ready) o.rd_hs++;
      end
      if (cd_do_full_write) begin
        o.arr_wr++;
        o.wr_data = cd_raw_in;
        m_data[idx] = cd_raw_in;
        m_dirty[idx] = 1'b0;
      end
      if (done) begin
        o.done_c = c;
        o.wb = done_wrote_back;
        break;
      end
    end
    mem_rd_resp_valid = 1'b0;

    chk("wr_handshakes", 128'(o.wr_hs), 128'(dirty));
    chk("wr_valid_cycles", 128'(o.wr_cycles), 128'(dirty ? v.wr_stall + 1 : 0));
    chk("rd_handshakes", 128'(o.rd_hs), 128'(!v.op));
    chk("array_writes", 128'(o.arr_wr), 128'(!v.op));
    if (!v.op) chk("fill_data", o.wr_data, v.fdata);
    chk("protocol_errs", 128'(o.proto_err), 128'(0));
    chk("busy_ready_errs", 128'(o.busy_viol), 128'(0));
    chk("accept_wait", 128'(o.wait_c), 128'(0));
  endtask

  vec_t vecs[7];
  vec_t v;
  obs_t o;
  int   idx;
  bit   d;

  initial begin
    vecs[0] = '{1'b0, 11'h005, 2'd2, 1'b0, 128'h0, {4{32'hA5A5A5A5}}, 0, 0, 0, 1'b0, 5, 1'b0};
    vecs[1] = '{1'b0, 11'h100, 2'd1, 1'b1, {4{32'h12345678}}, {4{32'h0F0F0F0F}}, 3, 0, 0, 1'b0, 9, 1'b1};
    vecs[2] = '{1'b1, 11'h7FF, 2'd3, 1'b1, {4{32'hDEADBEEF}}, 128'h0, 0, 0, 0, 1'b0, 3, 1'b1};
    vecs[3] = '{1'b1, 11'h7FE, 2'd0, 1'b0, {4{32'hCAFEF00D}}, 128'h0, 0, 0, 0, 1'b0, 2, 1'b0};
    vecs[4] = '{1'b0, 11'h055, 2'd0, 1'b1, {4{32'h600DD00D}}, {4{32'h3C3C5A5A}}, 1, 0, 10, 1'b1, 17, 1'b1};
    vecs[5] = '{1'b0, 11'h003, 2'd3, 1'b0, 128'h0, {4{32'h11112222}}, 0, 2, 1, 1'b0, 8, 1'b0};
    vecs[6] = '{1'b1, 11'h200, 2'd1, 1'b1, {4{32'h87654321}}, 128'h0, 2, 0, 0, 1'b1, 5, 1'b1};

    main_rst = 1'b1; req_valid = 1'b1; req_op = 1'b0; req_segment = '0; req_way = '0;
    req_wb_addr = '0; req_fill_addr = '0; cd_raw_out = '0; cd_dirty = 1'b0;
    mem_wr_ready = 1'b0; mem_rd_ready = 1'b0; mem_rd_resp_valid = 1'b0; mem_rd_resp_data = '0;
    repeat (3) @(negedge main_clk);
    #1;
    chk("rst_req_ready", 128'(req_ready), 128'(0));
    chk("rst_outputs", 128'({busy, done, done_wrote_back, cd_do_full_write, mem_wr_valid, mem_rd_valid}), 128'(0));
    req_valid = 1'b0;
    main_rst = 1'b0;
    @(negedge main_clk);
    drive_array();
    #1;
    chk("idle_req_ready", 128'(req_ready), 128'(1));
    chk("idle_busy", 128'(busy), 128'(0));

    foreach (vecs[i]) begin
      idx = int'({vecs[i].seg, vecs[i].way});
      m_data[idx] = vecs[i].victim;
      m_dirty[idx] = vecs[i].dirty;
      run_txn(vecs[i], ADDR_W'(32'h0100_0000 + i), ADDR_W'(32'h0200_0000 + i), 1'b0, -1, o);
      chk($sformatf("vec%0d_done_cycle", i), 128'(o.done_c), 128'(vecs[i].exp_done));
      chk($sformatf("vec%0d_wrote_back", i), 128'(o.wb), 128'(vecs[i].exp_wb));
    end

    // Reset during WB of a dirty refill, then during FWAIT of a clean refill
    v = '{1'b0, 11'h0AA, 2'd1, 1'b1, {4{32'hFEEDFACE}}, {4{32'h99999999}}, 5, 0, 0, 1'b0, 0, 1'b0};
    idx = int'({v.seg, v.way});
    m_data[idx] = v.victim; m_dirty[idx] = 1'b1;
    run_txn(v, ADDR_W'(32'h123), ADDR_W'(32'h456), 1'b0, 5, o);
    chk("rst_wb_no_done", 128'(o.done_c), 128'(-1));
    chk("rst_wb_quiet", 128'(o.busy_viol + o.arr_wr), 128'(0));
    v = '{1'b0, 11'h0AB, 2'd2, 1'b0, 128'h0, {4{32'h77777777}}, 0, 0, 8, 1'b0, 0, 1'b0};
    run_txn(v, ADDR_W'(32'h789), ADDR_W'(32'hABC), 1'b0, 7, o);
    chk("rst_fwait_no_done", 128'(o.done_c), 128'(-1));
    chk("rst_fwait_quiet", 128'(o.busy_viol + o.arr_wr), 128'(0));
    chk("rst_fwait_array_untouched", m_get(int'({11'h0AB, 2'd2})), 128'h0);
    v = '{1'b0, 11'h0AA, 2'd1, 1'b0, 128'h0, {4{32'h24682468}}, 0, 0, 0, 1'b0, 0, 1'b0};
    run_txn(v, ADDR_W'(32'h123), ADDR_W'(32'h456), 1'b0, -1, o);
    chk("post_rst_done_cycle", 128'(o.done_c), 128'(exp_done_cycle(1'b0, 1'b1, 0, 0, 0)));

    // req_valid held high across three requests: each accepted in the single IDLE cycle after done
    for (int k = 0; k < 3; k++) begin
      v = '{1'b0, 11'(12'h300 + k), 2'd0, 1'b0, 128'h0, {4{$urandom}}, 0, 0, 0, 1'b0, 0, 1'b0};
      m_dirty[int'({v.seg, v.way})] = 1'b0;
      run_txn(v, ADDR_W'($urandom), ADDR_W'($urandom), k < 2, -1, o);
      chk($sformatf("b2b%0d_done_cycle", k), 128'(o.done_c), 128'(5));
    end

    for (int n = 0; n < 40; n++) begin
      v.op = 1'($urandom_range(0, 1));
      v.seg = 11'($urandom_range(0, 15));
      v.way = 2'($urandom_range(0, 3));
      v.fdata = {$urandom, $urandom, $urandom, $urandom};
      v.wr_stall = $urandom_range(0, 3);
      v.rd_stall = $urandom_range(0, 3);
      v.resp_delay = $urandom_range(0, 5);
      v.stray = 1'($urandom_range(0, 1));
      idx = int'({v.seg, v.way});
      if ($urandom_range(0, 1) == 1) begin
        m_data[idx] = {$urandom, $urandom, $urandom, $urandom};
        m_dirty[idx] = 1'($urandom_range(0, 1));
      end
      d = m_get_dirty(idx);
      run_txn(v, ADDR_W'($urandom), ADDR_W'($urandom), 1'b0, -1, o);
      chk($sformatf("rnd%0d_done_cycle", n), 128'(o.done_c),
          128'(exp_done_cycle(v.op, d, v.wr_stall, v.rd_stall, v.resp_delay)));
      chk($sformatf("rnd%0d_wrote_back", n), 128'(o.wb), 128'(d));
      chk($sformatf("rnd%0d_dirty_after", n), 128'(m_get_dirty(idx)), 128'(v.op ? d : 1'b0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cache_line_sequencer.md
# cache_line_sequencer

Controls one line transaction at a time against the cache data array: refill, writeback-then-refill, or flush. It reads the victim line and its dirty bit from the array. A dirty line is written to memory over a valid/ready channel. For a refill, the block then fetches the new 128-bit line from memory and installs it with a full-line write, which also clears the dirty bit. It sits between the cache tag/miss logic (requester) and the memory interface, and owns the data array's address and full-write ports while busy.

## Interface
Parameters:
- ADDR_W, 26, width of line address (128-bit line granularity)

Ports:
- main_clk  in  1  clock; all state on rising edge
- main_rst  in  1  asynchronous, active-high reset
- req_valid  in  1  transaction request
- req_ready  out  1  high only in IDLE with main_rst low
- req_op  in  1  0 = refill (writeback if dirty, then fill), 1 = flush (writeback if dirty only)
- req_segment  in  11  array segment
- req_way  in  2  array way
- req_wb_addr  in  ADDR_W  memory line address for victim writeback
- req_fill_addr  in  ADDR_W  memory line address to fetch (ignored for flush)
- done  out  1  one-cycle pulse at transaction completion
- done_wrote_back  out  1  valid with done: 1 if a writeback occurred
- busy  out  1  high when state != IDLE; upstream muxes array ports to this block when high
- cd_target_segment  out  11  array segment (latched request)
- cd_target_way  out  2  array way (latched request)
- cd_do_full_write  out  1  full-line write strobe
- cd_raw_in  out  128  line data to write
- cd_raw_out  in  128  array read data, 1-cycle registered read latency
- cd_dirty  in  1  dirty bit, same latency as cd_raw_out
- mem_wr_valid  out  1  writeback request
- mem_wr_ready  in  1  writeback accept
- mem_wr_addr  out  ADDR_W  writeback address
- mem_wr_data  out  128  writeback data
- mem_rd_valid  out  1  fill read request
- mem_rd_ready  in  1  fill read accept
- mem_rd_addr  out  ADDR_W  fill address
- mem_rd_resp_valid  in  1  fill data valid
- mem_rd_resp_data  in  128  fill data

## Operation
- States: IDLE, RD, CAP, WB, FREQ, FWAIT, WR.
- IDLE: on req_valid&req_ready, latch op, segment, way, and both addresses, then go to RD. Latched values hold constant until return to IDLE.
- RD: the array address is driven from the latched values with no write. Go to CAP.
- CAP: latch cd_raw_out into the writeback buffer and latch cd_dirty.
  - dirty: go to WB.
  - clean, refill: go to FREQ.
  - clean, flush: pulse done and go to IDLE.
- WB: hold mem_wr_valid=1 with stable addr/data until mem_wr_ready. On that cycle, go to FREQ for a refill. For a flush, pulse done with done_wrote_back=1 and go to IDLE.
- FREQ: hold mem_rd_valid=1 with stable addr until mem_rd_ready, then go to FWAIT.
- FWAIT: on mem_rd_resp_valid, latch mem_rd_resp_data and go to WR. Responses in any other state are ignored.
- WR: cd_do_full_write=1 for exactly one cycle, with cd_raw_in = latched fill data. Pulse done in the same cycle, then go to IDLE.
- Flush does not write the array and does not clear dirty; the requester invalidates tags.
- cd_do_full_write is high only in WR. mem_wr_valid is high only in WB. mem_rd_valid is high only in FREQ.

## Timing
- Reset (async, takes effect immediately): state=IDLE, and done, done_wrote_back, cd_do_full_write, mem_wr_valid, mem_rd_valid are all 0. busy=0 and req_ready=0 while main_rst is high. Latched address/data registers reset to 0.
- Reset mid-transaction aborts it: no done, no array write. Any outstanding memory response after deassertion is ignored, because the block is in IDLE.
- Request accepted at edge 0. RD in cycle 1, CAP in cycle 2.
- Clean refill with zero-wait memory (ready=1, response in the first FWAIT cycle): FREQ in cycle 3, FWAIT in cycle 4, WR plus done in cycle 5, req_ready=1 in cycle 6.
- Each dirty writeback adds at least 1 cycle, plus 1 per cycle that mem_wr_ready is low.
- Clean flush: done in cycle 2 (CAP).
- req_valid while busy is not accepted and is not latched; the requester holds it.
- Back-to-back transactions: minimum one IDLE cycle between done and the next acceptance.

## Test plan
- Clean refill, seg=0x005, way=2, fill data 0xA5A5..., zero-wait memory -> no mem_wr_valid, mem_rd_addr=req_fill_addr, cd_do_full_write in cycle 5 with cd_raw_in=0xA5A5..., done in cycle 5 with done_wrote_back=0.
- Dirty refill: victim line 0x1234..., mem_wr_ready low for 3 cycles -> mem_wr_data/addr stable for 4 cycles, the fill follows, done_wrote_back=1, one array write.
- Flush dirty then flush clean -> dirty: one mem_wr transaction, no mem_rd, no array write, done_wrote_back=1. Clean: done in cycle 2, no memory traffic.
- Delayed fill response (10 cycles), with a stray mem_rd_resp_valid injected during WB -> stray response ignored; only the FWAIT response is written.
- main_rst pulsed during WB and during FWAIT -> outputs zero immediately, no done, no cd_do_full_write; a subsequent request completes normally.
- req_valid held high continuously across 3 requests -> each accepted only in IDLE, exactly one done per request, busy deasserts for exactly one cycle between them.
